// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
// Optional feature macro: FIFO_ARB_BURST_EN (burst locking up to MAX_BURST beats).
package fifo_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Stateless round-robin picker: first set request searching upward from last_id+1.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDW     = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_id,
  output logic               found,
  output logic [IDW-1:0]     winner
);

  int unsigned w_idx;

  // Walk offsets from farthest to nearest so the nearest set request wins
  always_comb begin
    found  = 1'b0;
    winner = '0;
    w_idx  = 0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      w_idx = (32'(last_id) + k) % NUM_REQ;
      if (req[IDW'(w_idx)]) begin
        found  = 1'b1;
        winner = IDW'(w_idx);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync FIFO write port among NUM_REQ producers.
// Optional macro FIFO_ARB_BURST_EN: hold a grant for up to MAX_BURST beats;
// without it every accepted word releases the grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_w_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  output logic                            grant_valid,
  output logic [idx_width(NUM_REQ)-1:0]   grant_id
);

  localparam int unsigned IDW = idx_width(NUM_REQ);
  localparam logic [0:0] ST_IDLE  = ARB_IDLE;
  localparam logic [0:0] ST_GRANT = ARB_GRANT;

  // Reject configurations the arbiter cannot support
  if (NUM_REQ < 2 || MAX_BURST < 1) begin : g_bad_param
    $error("fifo_wr_arbiter: NUM_REQ must be >= 2 and MAX_BURST >= 1");
  end

  logic [0:0]     r_state, w_nxt_state;
  logic           r_grant_valid, w_nxt_grant_valid;
  logic [IDW-1:0] r_grant_id, w_nxt_grant_id;
  logic [IDW-1:0] r_last_id, w_nxt_last_id;

  logic           w_found;
  logic [IDW-1:0] w_winner;
  logic           w_hold_valid;
  logic           w_beat;
  logic           w_last_beat;

`ifdef FIFO_ARB_BURST_EN
  localparam int unsigned CNTW = idx_width(MAX_BURST + 1);
  logic [CNTW-1:0] r_beat_cnt, w_nxt_beat_cnt;

  // Final beat of a burst closes the grant
  assign w_last_beat = (r_beat_cnt == CNTW'(MAX_BURST - 1));
`else
  // Per-word round-robin: every beat is the last one
  assign w_last_beat = 1'b1;
`endif

  // Next holder candidate
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req     (req_valid),
    .last_id (r_last_id),
    .found   (w_found),
    .winner  (w_winner)
  );

  // A beat needs a live grant, a valid holder, FIFO room and no reset this cycle
  assign w_hold_valid = req_valid[r_grant_id];
  assign w_beat       = (r_state == ST_GRANT) & w_hold_valid & ~fifo_full & rst_n;

  // FIFO write port and producer back-pressure
  assign fifo_w_en    = w_beat;
  assign req_ready    = w_beat ? (NUM_REQ'(1) << r_grant_id) : '0;
  assign fifo_data_in = req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign grant_valid  = r_grant_valid;
  assign grant_id     = r_grant_id;

  // Next-state and grant bookkeeping
  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_grant_valid = r_grant_valid;
    w_nxt_grant_id    = r_grant_id;
    w_nxt_last_id     = r_last_id;
`ifdef FIFO_ARB_BURST_EN
    w_nxt_beat_cnt    = r_beat_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_nxt_state       = ST_GRANT;
          w_nxt_grant_valid = 1'b1;
          w_nxt_grant_id    = w_winner;
          w_nxt_last_id     = w_winner;
`ifdef FIFO_ARB_BURST_EN
          w_nxt_beat_cnt    = '0;
`endif
        end
      end
      ST_GRANT: begin
`ifdef FIFO_ARB_BURST_EN
        if (w_beat) begin
          w_nxt_beat_cnt = r_beat_cnt + CNTW'(1);
        end
`endif
        // Holder withdrew, or its burst is used up
        if (!w_hold_valid || (w_beat && w_last_beat)) begin
          w_nxt_state       = ST_IDLE;
          w_nxt_grant_valid = 1'b0;
        end
      end
      default: begin
        w_nxt_state       = ST_IDLE;
        w_nxt_grant_valid = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_last_id     <= IDW'(NUM_REQ - 1);
`ifdef FIFO_ARB_BURST_EN
      r_beat_cnt    <= '0;
`endif
    end else begin
      r_state       <= w_nxt_state;
      r_grant_valid <= w_nxt_grant_valid;
      r_grant_id    <= w_nxt_grant_id;
      r_last_id     <= w_nxt_last_id;
`ifdef FIFO_ARB_BURST_EN
      r_beat_cnt    <= w_nxt_beat_cnt;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a transaction-level arbitration model
// predicts each FIFO write; a separate monitor checks writes as they appear.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;
`ifdef FIFO_ARB_BURST_EN
  localparam int BURST = MB;
`else
  localparam int BURST = 1;
`endif

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_data_in;
  logic            grant_valid;
  logic [1:0]      grant_id;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            grant_log[$];
  logic [DW-1:0] p_word [N];

  // Reference model: who holds the port, beats used, who won last
  bit m_busy;
  int m_holder;
  int m_beats;
  int m_last;
  bit prev_gv;

  int total;
  int bad;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_holder = 0;
    m_beats  = 0;
    m_last   = N - 1;
  endtask

  // One clock of stimulus plus the model's prediction for it
  task automatic step(input logic [N-1:0] v, input logic f, input logic r);
    bit beat;
    int exp_ready;
    @(negedge clk);
    req_valid = v;
    fifo_full = f;
    rst_n     = r;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = p_word[i];
    #1;
    chk("grant_valid", int'(grant_valid), int'(m_busy));
    if (m_busy) chk("grant_id", int'(grant_id), m_holder);
    if (grant_valid === 1'b1 && !prev_gv) grant_log.push_back(int'(grant_id));
    prev_gv = (grant_valid === 1'b1);

    beat      = m_busy && r && v[m_holder] && !f;
    exp_ready = beat ? (1 << m_holder) : 0;
    chk("req_ready", int'(req_ready), exp_ready);
    if (beat) exp_q.push_back('{m_holder, p_word[m_holder]});

    if (!r) begin
      model_reset();
    end else if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        if (v[(m_last + k) % N]) begin
          m_busy   = 1'b1;
          m_holder = (m_last + k) % N;
          m_last   = m_holder;
          m_beats  = 0;
          break;
        end
      end
    end else begin
      if (beat) begin
        m_beats++;
        p_word[m_holder] = p_word[m_holder] + 8'd1;
      end
      if (!v[m_holder] || m_beats == BURST) m_busy = 1'b0;
    end
  endtask

  // Monitor: every FIFO write must match the oldest predicted write
  initial begin
    wr_t e;
    int  rid;
    forever begin
      @(negedge clk);
      #2;
      if (fifo_w_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e   = exp_q.pop_front();
          rid = -1;
          for (int i = 0; i < N; i++) if (req_ready[i]) rid = i;
          chk("wr_data", int'(fifo_data_in), int'(e.data));
          chk("wr_port", rid, e.id);
        end
      end
      if (exp_q.size() != 0) begin
        chk("missing_write", exp_q.size(), 0);
        exp_q.delete();
      end
    end
  end

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    total = 0;
    bad   = 0;
    prev_gv = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    rst_n     = 1'b0;
    for (int i = 0; i < N; i++) p_word[i] = 8'(i << 6);
    model_reset();

    // Reset state
    repeat (3) step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b1);
    chk("rst_w_en", int'(fifo_w_en), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_data_slice0", int'(fifo_data_in), int'(p_word[0]));

    // All producers valid: grants rotate 0,1,2,3,0 starting from producer 0
    grant_log.delete();
    repeat (5 * (BURST + 1) + 2) step('1, 1'b0, 1'b1);
    chk("grant_count_ge5", int'(grant_log.size() >= 5), 1);
    for (int i = 0; i < 5 && i < grant_log.size(); i++)
      chk($sformatf("grant_order%0d", i), grant_log[i], exp_order[i]);

    // Reset in the middle of a burst, then producer 0 wins first again
    step('1, 1'b0, 1'b0);
    chk("midrst_no_write", int'(fifo_w_en), 0);
    grant_log.delete();
    step('1, 1'b0, 1'b1);
    step('1, 1'b0, 1'b1);
    chk("post_rst_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);

    // Full stall on a single producer
    step(4'b0010, 1'b0, 1'b1);
    repeat (3) step(4'b0010, 1'b1, 1'b1);
    repeat (8) step(4'b0010, 1'b0, 1'b1);

    // Randomized valid, full and occasional reset
    for (int c = 0; c < 3000; c++) begin
      step(N'($urandom), ($urandom % 5) == 0, ($urandom % 250) != 0);
    end
    repeat (4) step('0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-side arbiter that shares one synchronous FIFO write port (w_en / data_in / full) among NUM_REQ independent producers. Each producer uses a valid/ready handshake. The arbiter locks a grant for a bounded burst, steers the winner's data onto the FIFO write port, and back-pressures everyone else. It sits directly in front of the team's sync FIFO; the FIFO's read side is untouched.

## Interface
Parameters:
- NUM_REQ, 4 — number of producers; at least 2.
- DATA_WIDTH, 8 — word width; must match the FIFO.
- MAX_BURST, 4 — maximum beats per grant; at least 1. Used only when FIFO_ARB_BURST_EN is defined.

Ports (reset rst_n, synchronous, active-low; clock clk):
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  producer i has a word.
- req_data  in  NUM_REQ*DATA_WIDTH  producer i's word in slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  one-hot or zero; word i is accepted this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_w_en  out  1  FIFO write enable.
- fifo_data_in  out  DATA_WIDTH  FIFO write data.
- grant_valid  out  1  registered; a grant is held.
- grant_id  out  $clog2(NUM_REQ)  registered; index of the holder.

## Operation
- The FSM has two states: IDLE and GRANT.
- **IDLE**
  - Outputs: req_ready=0, fifo_w_en=0.
  - If any req_valid is set, pick the first set index searching upward from (last_id+1) mod NUM_REQ.
  - Load grant_id ← winner, last_id ← winner, beat_cnt ← 0, then go to GRANT.
- **GRANT**, with g = grant_id:
  - beat = req_valid[g] & !fifo_full.
  - fifo_w_en = beat; req_ready[g] = beat; all other ready bits are 0.
  - fifo_data_in = req_data slice g. It is also driven during non-beat cycles; the value is don't-care.
  - On a beat, beat_cnt increments.
  - Go to IDLE when either condition holds:
    - req_valid[g]=0, whether or not fifo_full is set;
    - a beat occurs with beat_cnt == MAX_BURST-1.
  - Otherwise stay in GRANT.
- fifo_full with req_valid[g]=1: stall. No write, count held, grant held. This is the only way a grant lives longer than MAX_BURST cycles.
- Outputs are combinational from registered state plus req_valid and fifo_full. There is no combinational path from req_data to any control output.
- beat_cnt is $clog2(MAX_BURST+1) bits wide and never wraps; it clears on entry to GRANT.
- A producer that drops valid mid-burst forfeits the rest of the burst. It then competes normally and has lowest priority, because last_id points at it.
- The arbiter never writes when fifo_full=1, so the FIFO's internal full guard is never relied on.

## Timing
- Reset values: state IDLE, grant_valid 0, grant_id 0, last_id NUM_REQ-1 (producer 0 wins first), beat_cnt 0.
  - With the state at IDLE, req_ready is all 0, fifo_w_en is 0 and fifo_data_in is slice 0.
- Arbitration latency: a req_valid rise in cycle n while in IDLE gives a grant in n+1. The first beat can occur in n+1.
- Release overhead: each release costs one IDLE cycle. Sustained throughput is MAX_BURST/(MAX_BURST+1) beats per cycle.
- A handshake completes in the cycle where req_valid & req_ready is high. The producer must hold data and valid until then.
- Reset mid-burst: the next cycle is IDLE with reset values. A beat presented in the reset cycle is not written.

## Configuration
- Macro FIFO_ARB_BURST_EN.
- Defined: burst locking up to MAX_BURST beats, as described above.
- Not defined: MAX_BURST is ignored and treated as 1. Every beat releases the grant, giving strict per-word round-robin at a peak of 1 beat per 2 cycles. beat_cnt is not instantiated.

## Structure
- Package fifo_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_GRANT};
  - the width helper used for grant_id and beat_cnt.
- Sub-module rr_pick: combinational round-robin picker. Inputs are req vector and last_id; outputs are found and winner index. It has no state and is reusable by other arbiters.
- The top holds the FSM, counters and data mux.

## Test plan
- **Single producer:** after reset, req_valid=4'b0001, 6 words, FIFO never full, FIFO_ARB_BURST_EN, MAX_BURST=4 → writes at cycles 1–4, idle at cycle 5, writes at cycles 6–7; data order preserved.
- **All four valid continuously:** → grant order 0,1,2,3,0. Each grant gives 4 consecutive writes followed by 1 idle cycle.
- **fifo_full during a burst:** fifo_full asserted for 3 cycles after beat 2 of producer 1 → no w_en, grant_id stays 1, beats 3–4 follow once full drops, then producer 2 is granted.
- **Drop-out:** producer 2 drops valid after 1 beat → return to IDLE next cycle; producer 3 is granted before producer 2.
- **Reset mid-burst:** rst_n low for one cycle during producer 3's burst → grant_valid=0 next cycle, then producer 0 is granted first.
- **Macro undefined:** all valid → grant sequence 0,1,2,3, each with 1 beat followed by 1 idle cycle.
